// File: rtl/writeback_unit.sv
// Writeback stage: retires one instruction per handshake from MEM, waits for load data,
// formats it, and drives the register file's single write port plus the forwarding copy.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addrssw,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              reg_write;
    logic [2:0]        load_type;
    logic [ADDR_W-1:0] dst;
    logic [1:0]        off;
  } load_ctx_t;

  state_t    state;
  load_ctx_t ld;
  logic      accept;

  // Little-endian lane select from an aligned word; unknown codes pass the word through.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0] lt, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      LT_LB:   r = {{(DATA_W-8){b[7]}}, b};
      LT_LH:   r = {{(DATA_W-16){h[15]}}, h};
      LT_LBU:  r = {{(DATA_W-8){1'b0}}, b};
      LT_LHU:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign fwd_valid = rf_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld         <= '0;
      rf_write   <= 1'b0;
      rf_addrssw <= '0;
      rf_wdata   <= '0;
      retired    <= '0;
    end else begin
      rf_write <= 1'b0;
      case (state)
        IDLE: begin
          // dmem_rvalid is meaningless here: no load is outstanding yet.
          if (accept) begin
            if (in_mem_to_reg) begin
              ld.reg_write <= in_reg_write;
              ld.load_type <= in_load_type;
              ld.dst       <= in_dst;
              ld.off       <= in_alu_res[1:0];
              state        <= WAIT_LOAD;
            end else begin
              rf_write   <= in_reg_write & (in_dst != '0);
              rf_addrssw <= in_dst;
              rf_wdata   <= in_alu_res;
              retired    <= retired + CNT_ONE;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            rf_write   <= ld.reg_write & (ld.dst != '0);
            rf_addrssw <= ld.dst;
            rf_wdata   <= fmt_load(ld.load_type, ld.off, dmem_rdata);
            retired    <= retired + CNT_ONE;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized stream
// checked against a plain-arithmetic load/retire model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_reg_write, in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic [4:0]  in_dst;
  logic [31:0] in_alu_res;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        in_ready, rf_write, fwd_valid;
  logic [4:0]  rf_addrssw;
  logic [31:0] rf_wdata, retired;

  logic        w_in_ready, w_rf_write, w_fwd_valid;
  logic [4:0]  w_rf_addrssw;
  logic [31:0] w_rf_wdata;
  logic [3:0]  w_retired;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_ret = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .in_dst(in_dst), .in_alu_res(in_alu_res), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_write(rf_write), .rf_addrssw(rf_addrssw), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .retired(retired)
  );

  // Narrow-counter copy so the retirement counter wrap is reachable in a short run.
  writeback_unit #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .in_dst(in_dst), .in_alu_res(in_alu_res), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_write(w_rf_write), .rf_addrssw(w_rf_addrssw), .rf_wdata(w_rf_wdata),
    .fwd_valid(w_fwd_valid), .retired(w_retired)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * addr[1:0])) & 32'hFF;
    h = (w >> (16 * addr[1])) & 32'hFFFF;
    case (lt)
      3'b000:  return (b >= 128)   ? b - 256   : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_op(input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [4:0] dst, input logic [31:0] res, input logic rv);
    in_valid = 1'b1; in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
    in_dst = dst; in_alu_res = res; dmem_rvalid = rv; dmem_rdata = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic return_data(input logic [31:0] d);
    dmem_rvalid = 1'b1; dmem_rdata = d;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_load_type = 0;
    in_dst = 0; in_alu_res = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick(2);
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL reset_rf_write got %b want 0", rf_write); end
    n_vec++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    n_vec++; if (rf_addrssw !== 5'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", rf_addrssw); end
    rst = 1'b0; exp_ret = 0;
  endtask

  task automatic test_alu;
    drive_op(1'b1, 1'b0, 3'b0, 5'd5, 32'hDEADBEEF, 1'b0); exp_ret++;
    n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL alu_write got %b want 1", rf_write); end
    n_vec++; if (fwd_valid !== 1'b1) begin n_err++; $display("FAIL alu_fwd got %b want 1", fwd_valid); end
    n_vec++; if (rf_addrssw !== 5'd5) begin n_err++; $display("FAIL alu_addr got %0d want 5", rf_addrssw); end
    n_vec++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_wdata got %h want deadbeef", rf_wdata); end
    n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL alu_retired got %0d want %0d", retired, exp_ret); end
    tick(1);
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL alu_pulse got %b want 0", rf_write); end
  endtask

  task automatic test_loads;
    logic [2:0]  lts  [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] adrs [3] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011};
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, 1'b1, lts[i], 5'd8, adrs[i], 1'b0);
      for (int c = 0; c < 2; c++) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load%0d_wait_ready got %b want 0", i, in_ready); end
        n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL load%0d_wait_write got %b want 0", i, rf_write); end
        tick(1);
      end
      return_data(32'h80112233); exp_ret++;
      n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL load%0d_write got %b want 1", i, rf_write); end
      n_vec++; if (rf_addrssw !== 5'd8) begin n_err++; $display("FAIL load%0d_addr got %0d want 8", i, rf_addrssw); end
      n_vec++; if (rf_wdata !== exps[i]) begin n_err++; $display("FAIL load%0d_wdata got %h want %h", i, rf_wdata, exps[i]); end
      n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL load%0d_retired got %0d want %0d", i, retired, exp_ret); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL load%0d_ready got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_no_write;
    drive_op(1'b1, 1'b0, 3'b0, 5'd0, 32'h1234, 1'b0); exp_ret++;
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL dst0_write got %b want 0", rf_write); end
    n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL dst0_retired got %0d want %0d", retired, exp_ret); end
    drive_op(1'b0, 1'b0, 3'b0, 5'd7, 32'h5555, 1'b0); exp_ret++;
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL nowr_write got %b want 0", rf_write); end
    n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL nowr_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back;
    rst = 1'b1; tick(1); rst = 1'b0; exp_ret = 0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0;
      in_dst = 5'(i); in_alu_res = 32'h100 + 32'(i);
      @(posedge clk); #1; exp_ret++;
      n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL b2b%0d_write got %b want 1", i, rf_write); end
      n_vec++; if (rf_addrssw !== 5'(i)) begin n_err++; $display("FAIL b2b%0d_addr got %0d want %0d", i, rf_addrssw, i); end
      n_vec++; if (rf_wdata !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b%0d_wdata got %h", i, rf_wdata); end
    end
    in_valid = 1'b0;
    n_vec++; if (retired !== 32'd3) begin n_err++; $display("FAIL b2b_retired got %0d want 3", retired); end
    tick(1);
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL b2b_tail got %b want 0", rf_write); end
  endtask

  task automatic test_ignored_rvalid;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; tick(2); dmem_rvalid = 1'b0;
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL idle_rvalid_write got %b want 0", rf_write); end
    n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL idle_rvalid_retired got %0d want %0d", retired, exp_ret); end
    drive_op(1'b1, 1'b1, 3'b010, 5'd9, 32'h2000_0000, 1'b1);
    tick(1);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL same_rvalid_ready got %b want 0", in_ready); end
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL same_rvalid_write got %b want 0", rf_write); end
    return_data(32'h0BADC0DE); exp_ret++;
    n_vec++; if (rf_wdata !== 32'h0BADC0DE) begin n_err++; $display("FAIL same_rvalid_wdata got %h want 0badc0de", rf_wdata); end
    n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL same_rvalid_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid_load;
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0; in_dst = 5'd3; in_alu_res = 32'h77;
    rst = 1'b1; tick(1); in_valid = 1'b0; rst = 1'b0; exp_ret = 0;
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL rst_prio_write got %b want 0", rf_write); end
    n_vec++; if (retired !== 32'd0) begin n_err++; $display("FAIL rst_prio_retired got %0d want 0", retired); end
    drive_op(1'b1, 1'b1, 3'b010, 5'd4, 32'h3000_0000, 1'b0);
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    return_data(32'h12345678);
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL rst_mid_write got %b want 0", rf_write); end
    n_vec++; if (retired !== 32'd0) begin n_err++; $display("FAIL rst_mid_retired got %0d want 0", retired); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready2 got %b want 1", in_ready); end
  endtask

  task automatic test_random;
    logic [2:0]  lt_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic        rw, wr;
    logic [2:0]  lt;
    logic [4:0]  dst;
    logic [31:0] res, data, exp_d;
    for (int i = 0; i < 80; i++) begin
      rw  = ($urandom_range(0, 3) != 0);
      dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      res = $urandom;
      wr  = rw && (dst != 0);
      if ($urandom_range(0, 1) == 0) begin
        drive_op(rw, 1'b0, 3'($urandom_range(0, 7)), dst, res, 1'($urandom_range(0, 1)));
        exp_d = res;
      end else begin
        lt = lt_tab[$urandom_range(0, 7)];
        drive_op(rw, 1'b1, lt, dst, res, 1'($urandom_range(0, 1)));
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rnd%0d_wait_ready got %b want 0", i, in_ready); end
        tick($urandom_range(0, 3));
        data  = $urandom;
        exp_d = ref_load(lt, res, data);
        return_data(data);
      end
      exp_ret++;
      n_vec++; if (rf_write !== wr) begin n_err++; $display("FAIL rnd%0d_write got %b want %b", i, rf_write, wr); end
      n_vec++; if (retired !== exp_ret) begin n_err++; $display("FAIL rnd%0d_retired got %0d want %0d", i, retired, exp_ret); end
      if (wr) begin
        n_vec++; if (rf_addrssw !== dst) begin n_err++; $display("FAIL rnd%0d_addr got %0d want %0d", i, rf_addrssw, dst); end
        n_vec++; if (rf_wdata !== exp_d) begin n_err++; $display("FAIL rnd%0d_wdata got %h want %h", i, rf_wdata, exp_d); end
      end
      if ($urandom_range(0, 4) == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = $urandom; tick(1); dmem_rvalid = 1'b0;
        n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL rnd%0d_spurious got %b want 0", i, rf_write); end
      end
    end
    n_vec++; if (w_retired !== 4'(exp_ret)) begin n_err++; $display("FAIL wrap_retired got %0d want %0d", w_retired, exp_ret % 16); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_no_write;
    test_back_to_back;
    test_ignored_rvalid;
    test_reset_mid_load;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
